// File: rtl/life_pkg.sv
// Shared constants for the 7x7 Game of Life datapath: grid dimensions,
// program-pointer width and the mode encodings driven by the controlling FSM.
package life_pkg;

  localparam int ROWS  = 7;
  localparam int COLS  = 7;
  localparam int CELLS = ROWS * COLS;

  localparam int PTR_W = 6;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CELLS - 1);

  localparam logic [1:0] MODE_IDLE    = 2'b00;
  localparam logic [1:0] MODE_PROGRAM = 2'b01;
  localparam logic [1:0] MODE_RUN     = 2'b10;

  // Flat bit index of cell (r,c); row 0 occupies the low bits.
  function automatic int cell_idx(input int r, input int c);
    return r * COLS + c;
  endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Next-state rule for one Game of Life cell: live survives on 2 or 3
// neighbours, dead is born on exactly 3, everything else dies.
module life_cell_rule (
  input  logic       cur_i,
  input  logic [7:0] nbr_i,
  output logic       nxt_o
);

  logic [3:0] cnt;

  // Population count of the eight neighbours (0..8).
  always_comb begin
    cnt = 4'd0;
    for (int k = 0; k < 8; k++) begin
      cnt = cnt + {3'd0, nbr_i[k]};
    end
  end

  assign nxt_o = (cnt == 4'd3) | (cur_i & (cnt == 4'd2));

endmodule

// File: rtl/life_datapath_7x7.sv
// Registered 7x7 Game of Life datapath. PROGRAM mode loads cells one per
// clock from two buttons through a wrapping pointer; RUN mode advances one
// generation per clock; IDLE/reserved hold the grid. stop clears everything.
// Optional macro LIFE_TORUS_EN wraps neighbour selection modulo 7 in both
// axes; without it, neighbours outside the grid read as dead.
module life_datapath_7x7
  import life_pkg::*;
(
  input  logic        clka,
  input  logic        rst_n,
  input  logic [1:0]  state,
  input  logic        btn0,
  input  logic        btn1,
  input  logic        stop,
  output logic [48:0] grid
);

  logic [CELLS-1:0] grid_q, grid_d;
  logic [CELLS-1:0] grid_nxt;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Neighbour wiring and one rule instance per cell.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nbr;
      for (genvar dr = -1; dr <= 1; dr++) begin : g_dr
        for (genvar dc = -1; dc <= 1; dc++) begin : g_dc
          if (!(dr == 0 && dc == 0)) begin : g_nb
            // Neighbour slot 0..7 in raster order, skipping the centre.
            localparam int SLOT = ((dr + 1) * 3 + (dc + 1) < 4) ?
                                  ((dr + 1) * 3 + (dc + 1)) :
                                  ((dr + 1) * 3 + (dc + 1) - 1);
            localparam int NR = r + dr;
            localparam int NC = c + dc;
`ifdef LIFE_TORUS_EN
            localparam int WR = (NR + ROWS) % ROWS;
            localparam int WC = (NC + COLS) % COLS;
            assign nbr[SLOT] = grid_q[cell_idx(WR, WC)];
`else
            if (NR < 0 || NR >= ROWS || NC < 0 || NC >= COLS) begin : g_out
              assign nbr[SLOT] = 1'b0;
            end else begin : g_in
              assign nbr[SLOT] = grid_q[cell_idx(NR, NC)];
            end
`endif
          end
        end
      end

      life_cell_rule u_rule (
        .cur_i (grid_q[cell_idx(r, c)]),
        .nbr_i (nbr),
        .nxt_o (grid_nxt[cell_idx(r, c)])
      );
    end
  end

  // Next-state selection: stop beats the mode; pointer only survives in PROGRAM.
  always_comb begin
    grid_d = grid_q;
    ptr_d  = '0;
    if (stop) begin
      grid_d = '0;
    end else begin
      case (state)
        MODE_PROGRAM: begin
          ptr_d = ptr_q;
          if (btn0 ^ btn1) begin
            grid_d[ptr_q] = btn1;
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 6'd1;
          end
        end
        MODE_RUN: grid_d = grid_nxt;
        default:  grid_d = grid_q;
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      grid_q <= '0;
      ptr_q  <= '0;
    end else begin
      grid_q <= grid_d;
      ptr_q  <= ptr_d;
    end
  end

  assign grid = grid_q;

endmodule

// File: tb/tb_life_datapath_7x7.sv
// Bench for life_datapath_7x7: directed stimulus, a behavioural grid model
// checked every cycle, and hand-computed literal expectations.
module tb_life_datapath_7x7;

  localparam logic [1:0] M_IDLE = 2'b00;
  localparam logic [1:0] M_PROG = 2'b01;
  localparam logic [1:0] M_RUN  = 2'b10;
  localparam logic [1:0] M_RSV  = 2'b11;

  logic        clka;
  logic        rst_n;
  logic [1:0]  state;
  logic        btn0;
  logic        btn1;
  logic        stop;
  logic [48:0] grid;

  int total = 0;
  int bad   = 0;
  logic check_en = 1'b0;

  logic [48:0] m_grid;
  int          m_ptr;
  logic [48:0] exp_q[$];

  life_datapath_7x7 dut (
    .clka  (clka),
    .rst_n (rst_n),
    .state (state),
    .btn0  (btn0),
    .btn1  (btn1),
    .stop  (stop),
    .grid  (grid)
  );

  // clock
  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Game of Life next generation straight from the rules.
  function automatic logic [48:0] life_next(input logic [48:0] g);
    logic [48:0] n;
    int cnt, rr, cc;
    n = '0;
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 7; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
`ifdef LIFE_TORUS_EN
              rr = (rr + 7) % 7;
              cc = (cc + 7) % 7;
              cnt += int'(g[rr * 7 + cc]);
`else
              if (rr >= 0 && rr < 7 && cc >= 0 && cc < 7)
                cnt += int'(g[rr * 7 + cc]);
`endif
            end
          end
        end
        n[r * 7 + c] = (cnt == 3) || (g[r * 7 + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  // Behavioural model of the grid and program pointer.
  always @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      m_grid <= '0;
      m_ptr  <= 0;
    end else if (stop) begin
      m_grid <= '0;
      m_ptr  <= 0;
    end else if (state == M_PROG) begin
      if (btn0 != btn1) begin
        m_grid[m_ptr] <= btn1;
        m_ptr <= (m_ptr + 1) % 49;
      end
    end else if (state == M_RUN) begin
      m_grid <= life_next(m_grid);
      m_ptr  <= 0;
    end else begin
      m_ptr <= 0;
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clka) begin
    if (check_en) begin
      total++;
      if (grid !== m_grid) begin
        bad++;
        $display("FAIL model_cmp t=%0t: grid=%h expected=%h", $time, grid, m_grid);
      end
    end
  end

  task automatic check_lit(input string name, input logic [48:0] exp);
    total++;
    if (grid !== exp) begin
      bad++;
      $display("FAIL %s: grid=%h expected=%h", name, grid, exp);
    end
  endtask

  // Drive one clock's worth of inputs (called at a negedge, returns at the next).
  task automatic step(input logic [1:0] st, input logic b0, input logic b1, input logic sp);
    state = st;
    btn0  = b0;
    btn1  = b1;
    stop  = sp;
    @(negedge clka);
  endtask

  // Load a full 49-cell pattern starting from cell 0.
  task automatic program_grid(input logic [48:0] p);
    step(M_IDLE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 49; i++) step(M_PROG, ~p[i], p[i], 1'b0);
    step(M_IDLE, 1'b0, 1'b0, 1'b0);
  endtask

  logic [48:0] blinker_h, blinker_v, block, edge_in, edge_exp, all_but0;

  initial begin
    blinker_h = (49'd1 << 22) | (49'd1 << 23) | (49'd1 << 24);
    blinker_v = (49'd1 << 16) | (49'd1 << 23) | (49'd1 << 30);
    block     = (49'd1 << 0) | (49'd1 << 1) | (49'd1 << 7) | (49'd1 << 8);
    edge_in   = (49'd1 << 14) | (49'd1 << 21) | (49'd1 << 28);
`ifdef LIFE_TORUS_EN
    edge_exp  = (49'd1 << 21) | (49'd1 << 22) | (49'd1 << 27);
`else
    edge_exp  = (49'd1 << 21) | (49'd1 << 22);
`endif
    all_but0  = {{48{1'b1}}, 1'b0};

    // reset
    rst_n = 1'b0;
    state = M_IDLE;
    btn0 = 1'b0;
    btn1 = 1'b0;
    stop = 1'b0;
    @(negedge clka);
    check_lit("reset_grid", 49'h0);
    @(negedge clka);
    rst_n = 1'b1;
    check_en = 1'b1;
    @(negedge clka);

    // Program sequence from reset.
    step(M_PROG, 1'b1, 1'b0, 1'b0);
    repeat (5) step(M_PROG, 1'b0, 1'b1, 1'b0);
    step(M_PROG, 1'b1, 1'b0, 1'b0);
    step(M_PROG, 1'b0, 1'b1, 1'b0);
    repeat (2) step(M_PROG, 1'b1, 1'b0, 1'b0);
    repeat (2) step(M_PROG, 1'b0, 1'b1, 1'b0);
    step(M_PROG, 1'b0, 1'b0, 1'b0);
    check_lit("prog_seq", 49'h0000000000CBE);
    // Pointer sits at 12: next write lands on bit 12.
    step(M_PROG, 1'b0, 1'b1, 1'b0);
    check_lit("ptr_at_12", 49'h0000000001CBE);
    // Both buttons: no write, pointer holds at 13.
    step(M_PROG, 1'b1, 1'b1, 1'b0);
    check_lit("both_btn", 49'h0000000001CBE);
    step(M_PROG, 1'b0, 1'b1, 1'b0);
    check_lit("ptr_held", 49'h0000000003CBE);
    // Reserved mode holds the grid.
    step(M_RSV, 1'b0, 1'b1, 1'b0);
    check_lit("reserved_hold", 49'h0000000003CBE);

    // Blinker.
    program_grid(blinker_h);
    check_lit("blinker_load", blinker_h);
    exp_q.push_back(blinker_v);
    exp_q.push_back(blinker_h);
    exp_q.push_back(blinker_v);
    while (exp_q.size() > 0) begin
      step(M_RUN, 1'b0, 1'b0, 1'b0);
      check_lit("blinker_gen", exp_q.pop_front());
    end

    // Still life block.
    program_grid(block);
    repeat (10) exp_q.push_back(block);
    while (exp_q.size() > 0) begin
      step(M_RUN, 1'b0, 1'b0, 1'b0);
      check_lit("still_block", exp_q.pop_front());
    end

    // stop during RUN, then RUN keeps the empty grid empty.
    step(M_RUN, 1'b0, 1'b0, 1'b1);
    check_lit("stop_run", 49'h0);
    step(M_RUN, 1'b0, 1'b0, 1'b0);
    check_lit("run_empty", 49'h0);

    // Edge behaviour.
    program_grid(edge_in);
    step(M_RUN, 1'b0, 1'b0, 1'b0);
    check_lit("edge_blinker", edge_exp);

    // 49 writes then the 50th wraps to bit 0.
    step(M_IDLE, 1'b0, 1'b0, 1'b1);
    step(M_IDLE, 1'b0, 1'b0, 1'b0);
    repeat (49) step(M_PROG, 1'b0, 1'b1, 1'b0);
    check_lit("all_ones", {49{1'b1}});
    step(M_PROG, 1'b1, 1'b0, 1'b0);
    check_lit("wrap_bit0", all_but0);

    // Async reset mid-RUN, between edges.
    program_grid(blinker_h);
    step(M_RUN, 1'b0, 1'b0, 1'b0);
    check_lit("pre_reset_run", blinker_v);
    #2 rst_n = 1'b0;
    #1 check_lit("async_reset_now", 49'h0);
    @(negedge clka);
    check_lit("async_reset_held", 49'h0);
    @(negedge clka);
    rst_n = 1'b1;
    step(M_RUN, 1'b0, 1'b0, 1'b0);
    step(M_RUN, 1'b0, 1'b0, 1'b0);
    check_lit("run_after_reset", 49'h0);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
